uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_sync.sv | 22 ++
 rtl/uart_rx.sv | 196 +++++++++++++++++++
 tb/tb_uart_rx.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and receiver state type (UART_RX_PARITY_EN adds PARITY)
package uart_pkg;

  // Defaults shared with the transmitter so both ends agree on framing.
  localparam int DEFAULT_DATA_BITS  = 8;
  localparam int DEFAULT_OVERSAMPLE = 16;

  // Tick counter covers OVERSAMPLE up to 16; bit index covers up to 8 data bits.
  localparam int CNT_W = 4;
  localparam int IDX_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } uart_rx_state_e;

endpackage

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - two-flop synchronizer for the idle-high serial line
module uart_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two stages; both reset high so a reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver with valid/ready output (UART_RX_PARITY_EN adds even parity)
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DEFAULT_DATA_BITS,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 rx,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  logic rx_s;

  uart_rx_state_e        state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_BITS-1:0]  shreg_q, shreg_d;
  logic                  armed_q, armed_d;
  logic                  done_ok_q, done_ok_d;
  logic                  done_ferr_q, done_ferr_d;
`ifdef UART_RX_PARITY_EN
  logic                  par_bad_q, par_bad_d;
  logic                  done_perr_q, done_perr_d;
`endif

  uart_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  // Frame state, counters and completion flags; everything moves only on tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shreg_q     <= '0;
      armed_q     <= 1'b0;
      done_ok_q   <= 1'b0;
      done_ferr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q   <= 1'b0;
      done_perr_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      armed_q     <= armed_d;
      done_ok_q   <= done_ok_d;
      done_ferr_q <= done_ferr_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q   <= par_bad_d;
      done_perr_q <= done_perr_d;
`endif
    end
  end

  // Next-state logic: start qualification at mid start bit, then one sample per bit period.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shreg_d     = shreg_q;
    armed_d     = armed_q;
    done_ok_d   = 1'b0;
    done_ferr_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d   = par_bad_q;
    done_perr_d = 1'b0;
`endif
    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          // A line held low after a frame (break) must go high before a new start counts.
          if (!armed_q) begin
            armed_d = rx_s;
          end else if (!rx_s) begin
            state_d = ST_START;
            cnt_d   = '0;
          end
        end
        ST_START: begin
          if (cnt_q == HALF_M1) begin
            if (!rx_s) begin
              state_d = ST_DATA;
              cnt_d   = '0;
              idx_d   = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (cnt_q == FULL_M1) begin
            cnt_d   = '0;
            shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
            if (idx_q == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (cnt_q == FULL_M1) begin
            cnt_d     = '0;
            par_bad_d = rx_s ^ (^shreg_q);
            state_d   = ST_STOP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`endif
        ST_STOP: begin
          if (cnt_q == FULL_M1) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
            armed_d = 1'b0;
`ifdef UART_RX_PARITY_EN
            done_perr_d = par_bad_q;
            done_ok_d   = rx_s && !par_bad_q;
`else
            done_ok_d   = rx_s;
`endif
            done_ferr_d = !rx_s;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          armed_d = 1'b0;
        end
      endcase
    end
  end

  // Output word register and handshake; a completing frame takes priority over consumption.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= done_ferr_q;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= done_perr_q;
`endif
      if (done_ok_q) begin
        if (rx_valid && !rx_ready) begin
          overrun <= 1'b1;
        end else begin
          rx_data  <= shreg_q;
          rx_valid <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx (UART_RX_PARITY_EN enables parity scenarios)
module tb_uart_rx;

  localparam int DB = 8;
  localparam int OS = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tick = 1'b0;
  logic          rx = 1'b1;
  logic          rx_ready = 1'b0;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          frame_err;
  logic          overrun;
`ifdef UART_RX_PARITY_EN
  logic          parity_err;
`endif

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  int perr_cnt = 0;
  int wide_cnt = 0;
  logic ferr_prev = 1'b0;
  logic ovr_prev  = 1'b0;
  logic [DB-1:0] got_q[$];

  uart_rx #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .rx        (rx),
    .rx_ready  (rx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .overrun   (overrun)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  // Baud generator stand-in: one tick every 4 clocks.
  initial begin
    forever begin
      repeat (3) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  end

  // Observer: pulse counts, pulse widths, and words handed over on the handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_err) ferr_cnt++;
      if (overrun) ovr_cnt++;
`ifdef UART_RX_PARITY_EN
      if (parity_err) perr_cnt++;
`endif
      if ((frame_err && ferr_prev) || (overrun && ovr_prev)) wide_cnt++;
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
    end
    ferr_prev = frame_err;
    ovr_prev  = overrun;
  end

  task automatic clear_obs();
    ferr_cnt = 0;
    ovr_cnt  = 0;
    perr_cnt = 0;
    wide_cnt = 0;
    got_q.delete();
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (!tick) @(posedge clk);
    end
    #1;
  endtask

  task automatic send_idle(input int nbits);
    rx = 1'b1;
    wait_ticks(nbits * OS);
  endtask

  // Drives start, data, optional parity, then the stop bit up to just after its middle tick.
  task automatic send_head(input logic [DB-1:0] data, input logic par, input logic stop);
    rx = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < DB; i++) begin
      rx = data[i];
      wait_ticks(OS);
    end
    if (PAR_EN) begin
      rx = par;
      wait_ticks(OS);
    end
    rx = stop;
    wait_ticks(OS / 2 + 1);
  endtask

  task automatic send_tail();
    wait_ticks(OS / 2 - 1);
  endtask

  task automatic send_frame(input logic [DB-1:0] data, input logic par, input logic stop);
    send_head(data, par, stop);
    send_tail();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_cnt++; if (rx_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", rx_valid); else pass_cnt++;
    chk_cnt++; if (rx_data !== '0) $display("FAIL reset_data: got %h want 00", rx_data); else pass_cnt++;
    chk_cnt++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b want 0", frame_err); else pass_cnt++;
    chk_cnt++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", overrun); else pass_cnt++;
    rst_n = 1'b1;
    send_idle(2);
  endtask

  task automatic test_basic();
    clear_obs();
    rx_ready = 1'b0;
    send_head(8'hA5, ^8'hA5, 1'b1);
    chk_cnt++; if (rx_valid !== 1'b0) $display("FAIL basic_early_valid: got %b want 0", rx_valid); else pass_cnt++;
    @(posedge clk); #1;
    chk_cnt++; if (rx_valid !== 1'b1) $display("FAIL basic_latency_valid: got %b want 1", rx_valid); else pass_cnt++;
    chk_cnt++; if (rx_data !== 8'hA5) $display("FAIL basic_data: got %h want a5", rx_data); else pass_cnt++;
    send_tail();
    send_idle(2);
    chk_cnt++; if (rx_valid !== 1'b1) $display("FAIL basic_hold_valid: got %b want 1", rx_valid); else pass_cnt++;
    rx_ready = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0;
    chk_cnt++; if (rx_valid !== 1'b0) $display("FAIL basic_consume: got %b want 0", rx_valid); else pass_cnt++;
    chk_cnt++; if (ferr_cnt !== 0) $display("FAIL basic_no_ferr: got %0d want 0", ferr_cnt); else pass_cnt++;
  endtask

  task automatic test_glitch();
    clear_obs();
    rx_ready = 1'b1;
    rx = 1'b0;
    wait_ticks(4);
    send_idle(2);
    chk_cnt++; if (got_q.size() !== 0) $display("FAIL glitch_no_word: got %0d words want 0", got_q.size()); else pass_cnt++;
    chk_cnt++; if (ferr_cnt !== 0) $display("FAIL glitch_no_ferr: got %0d want 0", ferr_cnt); else pass_cnt++;
    send_frame(8'h3C, ^8'h3C, 1'b1);
    send_idle(1);
    chk_cnt++;
    if (got_q.size() !== 1 || got_q[0] !== 8'h3C)
      $display("FAIL glitch_next_frame: got %0d words first %h want 1 word 3c", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'h00);
    else pass_cnt++;
  endtask

  task automatic test_break();
    clear_obs();
    rx_ready = 1'b1;
    send_frame(8'h55, ^8'h55, 1'b0);
    rx = 1'b0;
    wait_ticks(40 * OS);
    chk_cnt++; if (ferr_cnt !== 1) $display("FAIL break_ferr_count: got %0d want 1", ferr_cnt); else pass_cnt++;
    chk_cnt++; if (wide_cnt !== 0) $display("FAIL break_pulse_width: got %0d wide cycles want 0", wide_cnt); else pass_cnt++;
    chk_cnt++; if (got_q.size() !== 0) $display("FAIL break_no_word: got %0d words want 0", got_q.size()); else pass_cnt++;
    send_idle(1);
    send_frame(8'h12, ^8'h12, 1'b1);
    send_idle(1);
    chk_cnt++;
    if (got_q.size() !== 1 || got_q[0] !== 8'h12)
      $display("FAIL break_recover: got %0d words first %h want 1 word 12", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'h00);
    else pass_cnt++;
    chk_cnt++; if (ferr_cnt !== 1) $display("FAIL break_ferr_final: got %0d want 1", ferr_cnt); else pass_cnt++;
  endtask

  task automatic test_overrun();
    clear_obs();
    rx_ready = 1'b0;
    send_frame(8'h3C, ^8'h3C, 1'b1);
    send_frame(8'hC3, ^8'hC3, 1'b1);
    send_idle(1);
    chk_cnt++; if (ovr_cnt !== 1) $display("FAIL overrun_pulse: got %0d want 1", ovr_cnt); else pass_cnt++;
    chk_cnt++; if (rx_data !== 8'h3C) $display("FAIL overrun_keep_data: got %h want 3c", rx_data); else pass_cnt++;
    chk_cnt++; if (wide_cnt !== 0) $display("FAIL overrun_width: got %0d wide cycles want 0", wide_cnt); else pass_cnt++;
    send_head(8'hC3, ^8'hC3, 1'b1);
    rx_ready = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0;
    chk_cnt++; if (rx_data !== 8'hC3) $display("FAIL same_cycle_data: got %h want c3", rx_data); else pass_cnt++;
    chk_cnt++; if (rx_valid !== 1'b1) $display("FAIL same_cycle_valid: got %b want 1", rx_valid); else pass_cnt++;
    send_tail();
    send_idle(1);
    chk_cnt++; if (ovr_cnt !== 1) $display("FAIL same_cycle_no_overrun: got %0d want 1", ovr_cnt); else pass_cnt++;
    rx_ready = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0;
  endtask

  task automatic test_parity();
    clear_obs();
    rx_ready = 1'b1;
    send_frame(8'h07, 1'b0, 1'b1);
    send_idle(1);
    chk_cnt++; if (perr_cnt !== 1) $display("FAIL parity_err_pulse: got %0d want 1", perr_cnt); else pass_cnt++;
    chk_cnt++; if (got_q.size() !== 0) $display("FAIL parity_discard: got %0d words want 0", got_q.size()); else pass_cnt++;
    send_frame(8'h07, 1'b1, 1'b1);
    send_idle(1);
    chk_cnt++;
    if (got_q.size() !== 1 || got_q[0] !== 8'h07)
      $display("FAIL parity_good: got %0d words first %h want 1 word 07", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'h00);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    rx_ready = 1'b1;
    rx = 1'b0;
    wait_ticks(OS);
    rx = 1'b1;
    wait_ticks(3 * OS);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_cnt++; if (rx_valid !== 1'b0) $display("FAIL midreset_valid: got %b want 0", rx_valid); else pass_cnt++;
    rst_n = 1'b1;
    clear_obs();
    send_idle(2);
    send_frame(8'h81, ^8'h81, 1'b1);
    send_idle(1);
    chk_cnt++;
    if (got_q.size() !== 1 || got_q[0] !== 8'h81)
      $display("FAIL midreset_word: got %0d words first %h want 1 word 81", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'h00);
    else pass_cnt++;
    chk_cnt++; if (ferr_cnt !== 0) $display("FAIL midreset_no_ferr: got %0d want 0", ferr_cnt); else pass_cnt++;
    chk_cnt++; if (ovr_cnt !== 0) $display("FAIL midreset_no_overrun: got %0d want 0", ovr_cnt); else pass_cnt++;
  endtask

  // Reference: a frame with a high stop bit delivers its byte, a low stop bit yields one frame_err.
  task automatic test_random();
    logic [DB-1:0] exp_q[$];
    int exp_ferr;
    logic [DB-1:0] d;
    logic stop;
    clear_obs();
    exp_ferr = 0;
    rx_ready = 1'b1;
    for (int n = 0; n < 14; n++) begin
      d    = DB'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      if (stop) exp_q.push_back(d);
      else exp_ferr++;
      send_frame(d, ^d, stop);
      if (!stop || ($urandom_range(0, 1) == 1)) send_idle(1);
    end
    send_idle(1);
    chk_cnt++; if (got_q.size() !== exp_q.size()) $display("FAIL random_count: got %0d words want %0d", got_q.size(), exp_q.size()); else pass_cnt++;
    chk_cnt++; if (ferr_cnt !== exp_ferr) $display("FAIL random_ferr: got %0d want %0d", ferr_cnt, exp_ferr); else pass_cnt++;
    for (int i = 0; i < exp_q.size(); i++) begin
      chk_cnt++;
      if (i >= got_q.size()) $display("FAIL random_word[%0d]: got none want %h", i, exp_q[i]);
      else if (got_q[i] !== exp_q[i]) $display("FAIL random_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_break();
    test_overrun();
    if (PAR_EN) test_parity();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
